// File: rtl/disp_scan.sv
// disp_scan -- multiplexed display scanner with double-buffered frame.
//
// Digits are shifted one at a time into a shadow buffer (load) and copied
// as a whole into the active frame (commit), so the visible frame never
// shows a half-written value. A prescaler divides clk by SCAN_DIV. On each
// scan step, one position of the active frame is presented on
// digit_pos/digit_cur and scan_tick pulses for one clock.
//
// Optional feature: define DISP_SCAN_BLANK_EN to enable leading-zero
// blanking. A nonzero position p is then driven as BLANK_CODE when
// active[p..NUM_DIGITS-1] are all zero. Position 0 is never blanked.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   digit_in   in   DIGIT_W  code shifted into shadow[0] on load
//   load       in   shift strobe
//   commit     in   shadow -> active copy strobe
//   digit_pos  out  POS_W    position being driven
//   digit_cur  out  DIGIT_W  code for digit_pos (after blanking)
//   scan_tick  out  one-clock pulse after each digit_pos/digit_cur update
module disp_scan #(
  parameter int unsigned        NUM_DIGITS = 6,
  parameter int unsigned        DIGIT_W    = 5,
  parameter int unsigned        SCAN_DIV   = 2,
  parameter logic [DIGIT_W-1:0] BLANK_CODE = '1,
  localparam int unsigned       POS_W      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               load,
  input  logic               commit,
  output logic [POS_W-1:0]   digit_pos,
  output logic [DIGIT_W-1:0] digit_cur,
  output logic               scan_tick
);

  localparam logic [15:0]      DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [POS_W-1:0] IDX_LAST = POS_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] active_q, active_d;
  logic [15:0]                        presc_q;
  logic [POS_W-1:0]                   scan_idx_q, scan_idx_d;
  logic [POS_W-1:0]                   digit_pos_q;
  logic [DIGIT_W-1:0]                 digit_cur_q, digit_cur_d;
  logic                               scan_tick_q;
  logic                               step;
  logic                               blank_w;

  assign step = (presc_q == DIV_LAST);

  always_comb begin
    shadow_d = shadow_q;
    if (load) begin
      shadow_d[0] = digit_in;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        shadow_d[i] = shadow_q[i-1];
      end
    end
  end

  // Commit takes the post-shift shadow so load+commit on one edge shows the new digit.
  assign active_d = commit ? shadow_d : active_q;

  // Explicit wrap keeps the index in range for non-power-of-2 NUM_DIGITS.
  assign scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + POS_W'(1);

`ifdef DISP_SCAN_BLANK_EN
  // Blank when this position and every higher one are zero; position 0 always shows.
  always_comb begin
    blank_w = (scan_idx_q != '0);
    for (int q = 0; q < NUM_DIGITS; q++) begin
      if (q >= int'(scan_idx_q) && active_q[q] != '0) begin
        blank_w = 1'b0;
      end
    end
  end
`else
  assign blank_w = 1'b0;
`endif

  // Uses active_q (pre-commit), so a commit on a step edge shows from the next step.
  assign digit_cur_d = blank_w ? BLANK_CODE : active_q[scan_idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      presc_q     <= '0;
      scan_idx_q  <= '0;
      digit_pos_q <= '0;
      digit_cur_q <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      scan_tick_q <= step;
      if (step) begin
        presc_q     <= '0;
        digit_pos_q <= scan_idx_q;
        digit_cur_q <= digit_cur_d;
        scan_idx_q  <= scan_idx_d;
      end else begin
        presc_q <= presc_q + 16'd1;
      end
    end
  end

  assign digit_pos = digit_pos_q;
  assign digit_cur = digit_cur_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_disp_scan.sv
module tb_disp_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] digit_in;
  logic       load, commit;
  logic [2:0] digit_pos;
  logic [4:0] digit_cur;
  logic       scan_tick;

  logic [4:0] digit_in5;
  logic       load5, commit5;
  logic [2:0] digit_pos5;
  logic [4:0] digit_cur5;
  logic       scan_tick5;

  int errors = 0;
  int checks = 0;

  // Value shown at a zero position above the highest nonzero digit.
`ifdef DISP_SCAN_BLANK_EN
  localparam logic [4:0] BL = 5'd31;
`else
  localparam logic [4:0] BL = 5'd0;
`endif

  logic [4:0] exp_f [6];

  always #5 clk = ~clk;

  disp_scan u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_in  (digit_in),
    .load      (load),
    .commit    (commit),
    .digit_pos (digit_pos),
    .digit_cur (digit_cur),
    .scan_tick (scan_tick)
  );

  disp_scan #(.NUM_DIGITS(5), .SCAN_DIV(1)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_in  (digit_in5),
    .load      (load5),
    .commit    (commit5),
    .digit_pos (digit_pos5),
    .digit_cur (digit_cur5),
    .scan_tick (scan_tick5)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance to the next scan step (bounded); returns the number of edges taken.
  task automatic wait_step(output int e);
    e = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      e++;
      if (scan_tick) return;
    end
    chk("step_timeout", scan_tick, 1);
  endtask

  // Ensure the next step will present position 0.
  task automatic sync_last();
    int e;
    if (digit_pos == 3'd5) return;
    for (int k = 0; k < 12; k++) begin
      wait_step(e);
      if (digit_pos == 3'd5) return;
    end
    chk("sync", digit_pos, 5);
  endtask

  task automatic check_frame(input string tag);
    int e;
    sync_last();
    for (int i = 0; i < 6; i++) begin
      wait_step(e);
      chk({tag, "_pos"}, digit_pos, i);
      chk({tag, "_cur"}, digit_cur, exp_f[i]);
      if (i > 0) chk({tag, "_gap"}, e, 2);
    end
  endtask

  task automatic load_digit(input logic [4:0] d, input logic c);
    digit_in = d;
    load     = 1'b1;
    commit   = c;
    @(posedge clk); #1;
    load     = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic commit_only();
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  initial begin
    int e;
    int          exp5  [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    logic [2:0]  pos36 [6]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [4:0]  cur36 [6]  = '{5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd9};

    rst_n = 1'b0; load = 1'b0; commit = 1'b0; digit_in = '0;
    load5 = 1'b0; commit5 = 1'b0; digit_in5 = '0;

    // Reset state
    #12;
    chk("rst_pos", digit_pos, 0);
    chk("rst_cur", digit_cur, 0);
    chk("rst_tick", scan_tick, 0);
    chk("rst_pos5", digit_pos5, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First step on the 2nd edge; SCAN_DIV=1 instance steps every edge and wraps 4->0
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("tick_div2", scan_tick, (k % 2 == 0) ? 1 : 0);
      chk("pos_n5", digit_pos5, exp5[k-1]);
      chk("tick_div1", scan_tick5, 1);
      if (k == 2) begin
        chk("first_pos", digit_pos, 0);
        chk("first_cur", digit_cur, 0);
      end
    end

    // Load without commit leaves the frame untouched
    load_digit(5'd7, 1'b0);
    exp_f = '{5'd0, BL, BL, BL, BL, BL};
    check_frame("nocommit");
    commit_only();
    exp_f = '{5'd7, BL, BL, BL, BL, BL};
    check_frame("load7");

    // Six loads, commit twice (second commit must see the same shadow)
    for (int i = 1; i <= 6; i++) load_digit(5'(i), 1'b0);
    commit_only();
    commit_only();
    exp_f = '{5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    check_frame("frame_a");
    check_frame("frame_b");

    // Load+commit on the edge that steps to position 0: old value shown there
    @(posedge clk); #1;
    digit_in = 5'd9; load = 1'b1; commit = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; commit = 1'b0;
    chk("coinc_tick", scan_tick, 1);
    chk("coinc_pos", digit_pos, 0);
    chk("coinc_cur", digit_cur, 6);
    for (int i = 0; i < 6; i++) begin
      wait_step(e);
      chk("after_pos", digit_pos, pos36[i]);
      chk("after_cur", digit_cur, cur36[i]);
    end

    // Blanking pattern {pos5..0} = 0,0,1,0,0,0; last load carries the commit
    load_digit(5'd0, 1'b0);
    load_digit(5'd0, 1'b0);
    load_digit(5'd1, 1'b0);
    load_digit(5'd0, 1'b0);
    load_digit(5'd0, 1'b0);
    load_digit(5'd0, 1'b1);
    exp_f = '{5'd0, 5'd0, 5'd0, 5'd1, BL, BL};
    check_frame("blank_a");
    for (int i = 0; i < 5; i++) load_digit(5'd0, 1'b0);
    load_digit(5'd0, 1'b1);
    exp_f = '{5'd0, BL, BL, BL, BL, BL};
    check_frame("blank_zero");

    // Reset mid-scan at position 3, with an uncommitted load pending
    for (int i = 0; i < 6; i++) load_digit(5'd1, 1'b0);
    commit_only();
    load_digit(5'd5, 1'b0);
    for (int k = 0; k < 12 && digit_pos != 3'd3; k++) wait_step(e);
    chk("pre_rst_pos", digit_pos, 3);
    chk("pre_rst_cur", digit_cur, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pos", digit_pos, 0);
    chk("async_cur", digit_cur, 0);
    chk("async_tick", scan_tick, 0);
    #3 rst_n = 1'b1;
    wait_step(e);
    chk("post_rst_gap", e, 2);
    chk("post_rst_pos", digit_pos, 0);
    chk("post_rst_cur", digit_cur, 0);
    commit_only();
    exp_f = '{5'd0, BL, BL, BL, BL, BL};
    check_frame("post_rst_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
